// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative multiply / divide unit for the execute stage.
//               Runs signed or unsigned MUL, DIV, MADD and MSUB on WIDTH-bit
//               operands and returns a 2*WIDTH result for the HI/LO pair.
//               Multiply is an LSB-first shift-add and divide is a restoring
//               divider. Both retire one bit per cycle on operand
//               magnitudes, and the signs are fixed up when the last step
//               completes.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start_i           - level request, sampled in IDLE only
//               annul_i           - abort the operation in flight
//               op_i              - 00 MUL, 01 DIV, 10 MADD, 11 MSUB
//               signed_i          - two's-complement operands
//               opdata1_i/2_i     - multiplicand/multiplier or dividend/divisor
//               hilo_i            - accumulator {HI,LO} for MADD/MSUB
//               result_o          - product/accumulation or {rem, quo}
//               ready_o           - result valid, held until start_i drops
//               busy_o            - high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [1:0]           op_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_byzero = 3'd1;
    localparam logic [2:0] c_st_run    = 3'd2;
    localparam logic [2:0] c_st_acc    = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [1:0] c_op_mul  = 2'b00;
    localparam logic [1:0] c_op_div  = 2'b01;
    localparam logic [1:0] c_op_madd = 2'b10;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Registered state
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_op;
    logic                 r_signed;
    logic                 r_sign1;
    logic                 r_sign2;
    logic [WIDTH-1:0]     r_opnd;    // multiplicand (MUL*) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0]   r_acc;     // {hi, multiplier} or {rem, quo} working pair
    logic [2*WIDTH-1:0]   r_hilo;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;
    logic                 r_busy;

    // Next-state values
    logic [2:0]           w_state_d;
    logic [CNT_W-1:0]     w_cnt_d;
    logic [1:0]           w_op_d;
    logic                 w_signed_d;
    logic                 w_sign1_d;
    logic                 w_sign2_d;
    logic [WIDTH-1:0]     w_opnd_d;
    logic [2*WIDTH-1:0]   w_acc_d;
    logic [2*WIDTH-1:0]   w_hilo_d;
    logic [2*WIDTH-1:0]   w_result_d;
    logic                 w_ready_d;
    logic                 w_busy_d;

    // Datapath intermediates
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_sub;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [2*WIDTH-1:0]   w_step;
    logic                 w_fix_pq;
    logic                 w_fix_rem;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [2*WIDTH-1:0]   w_run_res;
    logic [2*WIDTH-1:0]   w_acc_res;

    always_comb begin
        // Operand magnitudes; negating the most-negative value wraps to
        // itself, which read as unsigned is the correct magnitude.
        w_neg1 = signed_i & opdata1_i[WIDTH-1];
        w_neg2 = signed_i & opdata2_i[WIDTH-1];
        w_mag1 = w_neg1 ? -opdata1_i : opdata1_i;
        w_mag2 = w_neg2 ? -opdata2_i : opdata2_i;

        // Multiply step: add multiplicand to the upper half when the current
        // multiplier LSB is set, then shift the whole pair right. The carry
        // lands in the top bit.
        w_addend   = r_acc[0] ? r_opnd : {WIDTH{1'b0}};
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Restoring divide step. The shifted remainder needs WIDTH+1 bits.
        // When it is >= divisor, the difference always fits in WIDTH bits.
        w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_ge   = (w_rem_sh >= {1'b0, r_opnd});
        w_div_sub  = w_rem_sh[WIDTH-1:0] - r_opnd;
        w_div_step = w_div_ge ? {w_div_sub, r_acc[WIDTH-2:0], 1'b1}
                              : {r_acc[2*WIDTH-2:0], 1'b0};

        w_step = (r_op == c_op_div) ? w_div_step : w_mul_step;

        // Sign fix-up on the final step's value.
        w_fix_pq   = r_signed & (r_sign1 ^ r_sign2);
        w_fix_rem  = r_signed & r_sign1;
        w_prod_fix = w_fix_pq  ? -w_step : w_step;
        w_quo_fix  = w_fix_pq  ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
        w_rem_fix  = w_fix_rem ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
        w_run_res  = (r_op == c_op_div) ? {w_rem_fix, w_quo_fix} : w_prod_fix;

        w_acc_res  = (r_op == c_op_madd) ? (r_hilo + r_acc) : (r_hilo - r_acc);

        // Defaults: hold
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_op_d     = r_op;
        w_signed_d = r_signed;
        w_sign1_d  = r_sign1;
        w_sign2_d  = r_sign2;
        w_opnd_d   = r_opnd;
        w_acc_d    = r_acc;
        w_hilo_d   = r_hilo;
        w_result_d = r_result;
        w_ready_d  = r_ready;

        case (r_state)
            c_st_idle: begin
                w_ready_d = 1'b0;
                if (start_i && !annul_i) begin
                    w_op_d     = op_i;
                    w_signed_d = signed_i;
                    w_sign1_d  = w_neg1;
                    w_sign2_d  = w_neg2;
                    w_hilo_d   = hilo_i;
                    w_cnt_d    = '0;
                    if (op_i == c_op_div) begin
                        w_opnd_d = w_mag2;
                        w_acc_d  = {{WIDTH{1'b0}}, w_mag1};
                        w_state_d = (opdata2_i == '0) ? c_st_byzero : c_st_run;
                    end else begin
                        w_opnd_d  = w_mag1;
                        w_acc_d   = {{WIDTH{1'b0}}, w_mag2};
                        w_state_d = c_st_run;
                    end
                end
            end
            c_st_byzero: begin
                w_result_d = '0;
                w_ready_d  = 1'b1;
                w_state_d  = c_st_done;
            end
            c_st_run: begin
                w_acc_d = w_step;
                w_cnt_d = r_cnt + c_cnt_one;
                if (r_cnt == c_cnt_last) begin
                    if (r_op == c_op_mul || r_op == c_op_div) begin
                        w_result_d = w_run_res;
                        w_ready_d  = 1'b1;
                        w_state_d  = c_st_done;
                    end else begin
                        // Signed product parks in r_acc for the accumulate step
                        w_acc_d   = w_run_res;
                        w_state_d = c_st_acc;
                    end
                end
            end
            c_st_acc: begin
                w_result_d = w_acc_res;
                w_ready_d  = 1'b1;
                w_state_d  = c_st_done;
            end
            c_st_done: begin
                if (!start_i) begin
                    w_ready_d = 1'b0;
                    w_state_d = c_st_idle;
                end
            end
            default: begin
                w_ready_d = 1'b0;
                w_state_d = c_st_idle;
            end
        endcase

        // Annul wins over everything in flight and leaves the last result intact
        if (annul_i && (r_state != c_st_idle)) begin
            w_state_d  = c_st_idle;
            w_ready_d  = 1'b0;
            w_result_d = r_result;
        end

        w_busy_d = (w_state_d != c_st_idle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_signed <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hilo   <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_op     <= w_op_d;
            r_signed <= w_signed_d;
            r_sign1  <= w_sign1_d;
            r_sign2  <= w_sign2_d;
            r_opnd   <= w_opnd_d;
            r_acc    <= w_acc_d;
            r_hilo   <= w_hilo_d;
            r_result <= w_result_d;
            r_ready  <= w_ready_d;
            r_busy   <= w_busy_d;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_iter
// Description : Self-checking bench for muldiv_iter (WIDTH=32). Directed
//               vectors plus randomized operations are compared against a
//               plain-arithmetic reference model. The bench also covers
//               annul, asynchronous reset and back-to-back operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    localparam int WIDTH = 32;

    localparam logic [1:0] c_op_mul  = 2'b00;
    localparam logic [1:0] c_op_div  = 2'b01;
    localparam logic [1:0] c_op_madd = 2'b10;
    localparam logic [1:0] c_op_msub = 2'b11;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          annul_i;
    logic [1:0]    op_i;
    logic          signed_i;
    logic [31:0]   opdata1_i;
    logic [31:0]   opdata2_i;
    logic [63:0]   hilo_i;
    logic [63:0]   result_o;
    logic          ready_o;
    logic          busy_o;

    int            n_checks;
    int            n_fail;
    logic [63:0]   last_res;

    muldiv_iter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .op_i      (op_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hilo_i    (hilo_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the sign/zero-extended operands
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] hilo);
        logic signed [63:0] x, y, p, q, r;
        x = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        y = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        case (op)
            c_op_mul:  return p;
            c_op_div: begin
                if (b == 32'd0) return 64'd0;
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            c_op_madd: return hilo + p;
            default:   return hilo - p;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
        if (op == c_op_div && b == 32'd0) return 2;
        if (op == c_op_madd || op == c_op_msub) return WIDTH + 2;
        return WIDTH + 1;
    endfunction

    // Drive one request and wait for ready_o; lat counts rising edges from
    // the capture edge (cycle 0 -> 1) until ready_o is first seen, or -1.
    task automatic run_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] hilo,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        start_i   = 1'b1;
        annul_i   = 1'b0;
        op_i      = op;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        hilo_i    = hilo;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                // Inputs outside IDLE must be ignored
                op_i      = 2'($urandom);
                signed_i  = 1'($urandom);
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                hilo_i    = {$urandom, $urandom};
            end
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        res = result_o;
    endtask

    task automatic finish_op();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result_o); end
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
        last_res = 64'd0;
    endtask

    logic [1:0]  d_op   [6] = '{c_op_mul, c_op_div, c_op_div, c_op_div, c_op_madd, c_op_msub};
    logic        d_sgn  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d_a    [6] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [31:0] d_b    [6] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'd0, 32'd4, 32'd4};
    logic [63:0] d_hilo [6] = '{64'd0, 64'd0, 64'd0, 64'd0, 64'h10, 64'h10};
    logic [63:0] d_res  [6] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000,
                                64'd0, 64'h00000000_00000004, 64'h00000000_0000001C};
    int          d_lat  [6] = '{33, 33, 33, 2, 34, 34};

    task automatic test_directed();
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(d_op[i], d_sgn[i], d_a[i], d_b[i], d_hilo[i], res, lat);
            n_checks++;
            if (lat !== d_lat[i]) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, d_lat[i]); end
            n_checks++;
            if (res !== d_res[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, d_res[i]); end
            if (i == 0) begin
                // start_i still high: ready and result must hold
                @(posedge clk);
                #1;
                n_checks++;
                if (ready_o !== 1'b1 || result_o !== d_res[i]) begin
                    n_fail++; $display("FAIL done_hold: got ready=%b result=%h expected ready=1 result=%h", ready_o, result_o, d_res[i]);
                end
            end
            finish_op();
            n_checks++;
            if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL directed_release[%0d]: got ready=%b busy=%b expected 0/0", i, ready_o, busy_o);
            end
            n_checks++;
            if (result_o !== d_res[i]) begin n_fail++; $display("FAIL directed_result_hold[%0d]: got %h expected %h", i, result_o, d_res[i]); end
            last_res = d_res[i];
        end
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a, b;
        logic [63:0] hilo;
        int lat, sel;
        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom);
            a    = $urandom;
            b    = $urandom;
            hilo = {$urandom, $urandom};
            sel  = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = $urandom_range(1, 15);
            else if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 3) a = $urandom_range(0, 255);
            exp = ref_model(op, sgn, a, b, hilo);
            run_op(op, sgn, a, b, hilo, res, lat);
            n_checks++;
            if (lat !== exp_latency(op, b)) begin
                n_fail++; $display("FAIL random_latency[%0d] op=%0d: got %0d expected %0d", i, op, lat, exp_latency(op, b));
            end
            n_checks++;
            if (res !== exp) begin
                n_fail++; $display("FAIL random_result[%0d] op=%0d s=%b a=%h b=%h: got %h expected %h", i, op, sgn, a, b, res, exp);
            end
            finish_op();
            n_checks++;
            if (ready_o !== 1'b0) begin n_fail++; $display("FAIL random_release[%0d]: got ready=%b expected 0", i, ready_o); end
            last_res = exp;
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        bit seen_ready;
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b0; op_i = c_op_div; signed_i = 1'b0;
        opdata1_i = 32'd1000; opdata2_i = 32'd7; hilo_i = '0;
        @(posedge clk);              // capture; now cycle 1
        repeat (9) @(posedge clk);   // now cycle 10
        #1;
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL annul_busy_before: got %b expected 1", busy_o); end
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);              // cycle 11
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL annul_busy_after: got %b expected 0", busy_o); end
        @(negedge clk);
        annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready = 1'b1;
        end
        n_checks++;
        if (seen_ready) begin n_fail++; $display("FAIL annul_ready: got ready seen=1 expected 0"); end
        n_checks++;
        if (result_o !== last_res) begin n_fail++; $display("FAIL annul_result_hold: got %h expected %h", result_o, last_res); end

        // annul in IDLE blocks capture
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; op_i = c_op_mul; opdata1_i = 32'd6; opdata2_i = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL annul_idle_block: got busy=%b expected 0", busy_o); end

        run_op(c_op_mul, 1'b0, 32'd6, 32'd7, 64'd0, res, lat);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL annul_next_latency: got %0d expected 33", lat); end
        n_checks++;
        if (res !== 64'd42) begin n_fail++; $display("FAIL annul_next_result: got %h expected %h", res, 64'd42); end
        finish_op();
        last_res = 64'd42;
    endtask

    task automatic test_async_reset();
        logic [63:0] res, exp;
        int lat;
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b0; op_i = c_op_mul; signed_i = 1'b0;
        opdata1_i = 32'h12345678; opdata2_i = 32'h9ABCDEF0; hilo_i = '0;
        repeat (6) @(posedge clk);
        #2;
        start_i = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b ready=%b result=%h expected 0/0/0", busy_o, ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_idle: got busy=%b expected 0", busy_o); end
        exp = ref_model(c_op_msub, 1'b1, 32'hFFFF0001, 32'h00007FFF, 64'h0123456789ABCDEF);
        run_op(c_op_msub, 1'b1, 32'hFFFF0001, 32'h00007FFF, 64'h0123456789ABCDEF, res, lat);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL async_reset_latency: got %0d expected 34", lat); end
        n_checks++;
        if (res !== exp) begin n_fail++; $display("FAIL async_reset_result: got %h expected %h", res, exp); end
        finish_op();
        last_res = exp;
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, exp;
        int lat;
        // Each run_op re-raises start_i in the first IDLE cycle after the previous one
        for (int i = 0; i < 4; i++) begin
            exp = ref_model(c_op_div, 1'(i), 32'hFFFFFF00 + 32'(i), 32'd3 + 32'(i), 64'd0);
            run_op(c_op_div, 1'(i), 32'hFFFFFF00 + 32'(i), 32'd3 + 32'(i), 64'd0, res, lat);
            n_checks++;
            if (lat !== 33 || res !== exp) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got lat=%0d res=%h expected lat=33 res=%h", i, lat, res, exp);
            end
            finish_op();
            last_res = exp;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
